// File: rtl/sw_op_issue_arb.sv
`default_nettype none
// ============================================================================
// Module      : sw_op_issue_arb
// Description : Round-robin arbiter and sequencer in front of in_demux.
//               Grants one of NUM_REQ requesters, decodes the switch select,
//               tags each issued op with an op_id, applies per-switch FIFO
//               backpressure with a stall timeout and flags illegal selects.
//               Optional macro OP_ID_REQ_TAG_EN: op_id = {req_idx, seq[5:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_op_issue_arb #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int STALL_MAX   = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*5-1:0]       req_addr,
    input  logic [NUM_REQ*W_WIDTH-1:0] req_wr_data,
    input  logic [NUM_REQ-1:0]         req_wr_rd,
    input  logic [NUM_SW_INST-1:0]     sw_afull,
    output logic [2:0]                 sw_sel,
    output logic [4:0]                 addr,
    output logic [W_WIDTH-1:0]         wr_data,
    output logic                       wr_rd_op,
    output logic                       valid,
    output logic [7:0]                 op_id,
    output logic                       err_valid,
    output logic [1:0]                 err_code,
    output logic [1:0]                 err_req_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    localparam logic [3:0] c_num_sw     = 4'(NUM_SW_INST);
    localparam logic [2:0] c_num_req    = 3'(NUM_REQ);
    localparam logic [1:0] c_last_req   = 2'(NUM_REQ - 1);
    localparam logic [7:0] c_stall_last = 8'(STALL_MAX - 1);
`ifdef OP_ID_REQ_TAG_EN
    localparam int c_seq_w = 6;
`else
    localparam int c_seq_w = 8;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           w_req_valid_ext;
    logic [7:0]           w_afull_ext;
    logic                 w_found;
    logic [1:0]           w_gnt_idx;
    logic [2:0]           w_sum;
    logic [4:0]           w_gnt_addr;
    logic [W_WIDTH-1:0]   w_gnt_data;
    logic                 w_gnt_wr_rd;
    logic                 w_gnt_illegal;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_timeout;
    logic                 w_drop;
    logic                 w_stall;
    logic [7:0]           w_op_id;
    logic [1:0]           r_rr_ptr;
    logic [1:0]           r_req_idx;
    logic [4:0]           r_hold_addr;
    logic [W_WIDTH-1:0]   r_hold_data;
    logic                 r_hold_wr_rd;
    logic [c_seq_w-1:0]   r_seq;
    logic [7:0]           r_stall_cnt;

    // Pad the request-valid and afull vectors to their full index range so
    // that variable indexing never reaches past the real vector.
    for (genvar i = 0; i < 4; i++) begin : g_req_ext
        if (i < NUM_REQ) begin : g_map
            assign w_req_valid_ext[i] = req_valid[i];
        end else begin : g_pad
            assign w_req_valid_ext[i] = 1'b0;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_afull_ext
        if (i < NUM_SW_INST) begin : g_map
            assign w_afull_ext[i] = sw_afull[i];
        end else begin : g_pad
            assign w_afull_ext[i] = 1'b0;
        end
    end

`ifdef OP_ID_REQ_TAG_EN
    assign w_op_id = {r_req_idx, r_seq};
`else
    assign w_op_id = r_seq;
`endif

    // Round-robin search: first valid requester starting at the pointer.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = r_rr_ptr;
        w_sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + 3'(k);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            if (!w_found && w_req_valid_ext[w_sum[1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_sum[1:0];
            end
        end
    end

    // Select the granted requester's payload and check its switch select.
    always_comb begin
        w_gnt_addr  = '0;
        w_gnt_data  = '0;
        w_gnt_wr_rd = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == 2'(i)) begin
                w_gnt_addr  = req_addr[5*i +: 5];
                w_gnt_data  = req_wr_data[W_WIDTH*i +: W_WIDTH];
                w_gnt_wr_rd = req_wr_rd[i];
            end
        end
        w_gnt_illegal = ({1'b0, w_gnt_addr[4:2]} >= c_num_sw);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fire      = 1'b0;
        w_timeout   = 1'b0;
        w_drop      = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_gnt_illegal ? ST_DROP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!w_afull_ext[r_hold_addr[4:2]]) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_stall_cnt == c_stall_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_DROP: begin
                w_drop      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One-hot grant, forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && w_accept && (w_gnt_idx == 2'(i));
        end
    end

    // Hold registers, pointer, counters and registered demux/error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_req_idx    <= '0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
            r_hold_wr_rd <= 1'b0;
            r_seq        <= '0;
            r_stall_cnt  <= '0;
            sw_sel       <= '0;
            addr         <= '0;
            wr_data      <= '0;
            wr_rd_op     <= 1'b0;
            valid        <= 1'b0;
            op_id        <= '0;
            err_valid    <= 1'b0;
            err_code     <= '0;
            err_req_idx  <= '0;
        end else begin
            valid       <= w_fire;
            err_valid   <= w_drop | w_timeout;
            r_stall_cnt <= w_stall ? (r_stall_cnt + 8'd1) : 8'd0;
            if (w_accept) begin
                r_hold_addr  <= w_gnt_addr;
                r_hold_data  <= w_gnt_data;
                r_hold_wr_rd <= w_gnt_wr_rd;
                r_req_idx    <= w_gnt_idx;
                r_rr_ptr     <= (w_gnt_idx == c_last_req) ? 2'd0 : (w_gnt_idx + 2'd1);
            end
            if (w_fire) begin
                sw_sel   <= r_hold_addr[4:2];
                addr     <= r_hold_addr;
                wr_data  <= r_hold_data;
                wr_rd_op <= r_hold_wr_rd;
                op_id    <= w_op_id;
                r_seq    <= r_seq + 1'b1;
            end
            if (w_drop) begin
                err_code    <= 2'b01;
                err_req_idx <= r_req_idx;
            end
            if (w_timeout) begin
                err_code    <= 2'b10;
                err_req_idx <= r_req_idx;
            end
        end
    end

endmodule
`default_nettype wire
